input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Conditions raw asynchronous board inputs (slide switches, keys) before they reach the
//   CPU system's parallel input port. Per bit: 2-FF synchronizer, stability counter, one-cycle
//   rise/fall pulses and a sticky change-event register cleared by software-driven mask.
//   Sits between the board pins and the pio input of the Nios-II system.
// PARAMETERS
//   WIDTH            10         number of independent input bits
//   DEBOUNCE_CYCLES  1_000_000  cycles the synced input must differ continuously before
//                               acceptance (20 ms @ 50 MHz); legal range 2..2^24
//   SYNC_STAGES      2          synchronizer depth; legal range 2..4
// PORTS
//   clk          in   1      system clock (50 MHz board clock)
//   reset_n      in   1      asynchronous, active-low reset
//   in_raw_i     in   WIDTH  raw pin inputs, asynchronous to clk
//   in_stable_o  out  WIDTH  debounced level; drives the pio input port
//   rise_o       out  WIDTH  1-cycle pulse per bit when in_stable_o goes 0->1
//   fall_o       out  WIDTH  1-cycle pulse per bit when in_stable_o goes 1->0
//   event_o      out  WIDTH  sticky: bit set on any accepted change of that bit
//   clr_i        in   WIDTH  clear mask for event_o, sampled every cycle
// BEHAVIOUR
//   - One clock, reset is asynchronous and active-low; all flops clear on reset_n=0.
//   - Reset values: in_stable_o=0, rise_o=0, fall_o=0, event_o=0, sync chain=0, counters=0.
//   - Sync: in_raw_i passes SYNC_STAGES flops -> sync[i]; no combinational path raw->out.
//   - Per-bit counter cnt (CNT_W = $clog2(DEBOUNCE_CYCLES) bits):
//       sync==stable            : cnt <= 0
//       sync!=stable, cnt<D-1   : cnt <= cnt+1
//       sync!=stable, cnt==D-1  : stable <= sync, cnt <= 0, pulse rise/fall next edge
//     (D = DEBOUNCE_CYCLES). Counter never wraps; terminal value is D-1.
//   - Latency: a clean step on in_raw_i reaches in_stable_o after SYNC_STAGES+D cycles;
//     rise_o/fall_o assert in the same cycle in_stable_o changes, for exactly 1 cycle.
//   - Glitch: any return sync==stable before acceptance resets cnt; glitch shorter than
//     D cycles never changes in_stable_o and produces no pulse or event.
//   - event_o[i]: set on rise_o[i]|fall_o[i]; cleared when clr_i[i]=1. Set and clear in same
//     cycle -> set wins (no lost event). clr_i on a bit with event_o=0 has no effect.
//   - Bits are fully independent; simultaneous changes on several bits all reported.
//   - Post-reset: stable=0, so an input held high during reset is accepted after
//     SYNC_STAGES+D cycles with rise_o pulse and event set (intended power-up report).
//   - reset_n asserted mid-count: count discarded, outputs return to reset values at once.
// STRUCTURE
//   - Package input_ctrl_pkg: DEBOUNCE_20MS_50MHZ constant, SYNC_STAGES_DEFAULT,
//     function cnt_width(int cycles) returning $clog2 width.
//   - Sub-module debounce_bit (sync chain + counter + stable flop + edge pulses), instantiated
//     WIDTH times via generate; event register and clear logic stay in input_debouncer.
// TESTING  (bench overrides DEBOUNCE_CYCLES=8, WIDTH=4, SYNC_STAGES=2)
//   1. Reset held, in_raw_i=4'hF -> all outputs 0; release -> after 10 cycles
//      in_stable_o=4'hF, rise_o=4'hF for 1 cycle, event_o=4'hF.
//   2. Bit0 0->1 clean step -> in_stable_o[0]=1 exactly 10 cycles later, rise_o[0] 1 cycle,
//      no activity on bits 1..3.
//   3. Bit1 bounces: 5 cycles high, 1 low, 8 high -> single rise_o[1] pulse, timed from
//      start of final 8-cycle high run + 2 sync cycles; no fall_o.
//   4. Glitch 7 cycles high on bit2 then low -> in_stable_o[2] stays 0, event_o[2] stays 0.
//   5. event_o[3]=1, clr_i[3]=1 in same cycle as new fall_o[3] -> event_o[3] stays 1;
//      clr_i[3]=1 next cycle -> event_o[3]=0.
//   6. reset_n pulsed low at cnt=5 on bit0 -> outputs 0 immediately, count restarts from 0.

Source files
------------

// File: rtl/input_ctrl_pkg.sv
// Shared constants and helpers for the board input conditioning logic.
package input_ctrl_pkg;

  localparam int unsigned DEBOUNCE_20MS_50MHZ = 1_000_000;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Counter width able to hold the terminal value cycles-1.
  function automatic int unsigned cnt_width(int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchronizer, stability counter, debounced level and edge pulses.
module debounce_bit
  import input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;
  logic                   differ;
  logic                   accept;

  always_comb begin
    sync     = sync_q[SYNC_STAGES-1];
    differ   = (sync != stable_q);
    accept   = differ && (cnt_q == CntMax);
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (!differ || accept) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (accept) begin
      stable_d = sync;
    end
    // Pulses are registered alongside the level so they appear in the same cycle.
    rise_d = accept && sync;
    fall_d = accept && !sync;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH independent board inputs and keeps a sticky, software-clearable
// change-event register for the parallel input port.
module input_debouncer
  import input_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_raw_i,
  output logic [WIDTH-1:0] in_stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] event_o,
  input  logic [WIDTH-1:0] clr_i
);

  logic [WIDTH-1:0] event_q, event_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_i   (in_raw_i[gi]),
      .stable_o(in_stable_o[gi]),
      .rise_o  (rise_o[gi]),
      .fall_o  (fall_o[gi])
    );
  end

  // A new edge overrides a simultaneous clear so no change is ever lost.
  always_comb begin
    event_d = (event_q & ~clr_i) | rise_o | fall_o;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_q <= '0;
    end else begin
      event_q <= event_d;
    end
  end

  assign event_o = event_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a cycle-level behavioural model.
module tb_input_debouncer;

  localparam int unsigned W    = 4;
  localparam int unsigned D    = 8;
  localparam int unsigned SYNC = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_raw;
  logic [W-1:0] in_stable;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] event_v;
  logic [W-1:0] clr;

  int checks = 0;
  int errors = 0;

  input_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_raw_i   (in_raw),
    .in_stable_o(in_stable),
    .rise_o     (rise),
    .fall_o     (fall),
    .event_o    (event_v),
    .clr_i      (clr)
  );

  always #5 clk = ~clk;

  // Model: a bit is accepted once its input, seen SYNC edges late, has disagreed with the
  // accepted level for D consecutive edges.
  logic [W-1:0] hist[$] = '{4'h0, 4'h0};
  int           run[W];
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_rise   = '0;
  logic [W-1:0] m_fall   = '0;
  logic [W-1:0] m_event  = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist     = '{4'h0, 4'h0};
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_event  = '0;
      for (int b = 0; b < W; b++) run[b] = 0;
    end else begin : m_step
      logic [W-1:0] seen;
      seen    = hist[hist.size() - SYNC];
      m_event = (m_event & ~clr) | m_rise | m_fall;
      m_rise  = '0;
      m_fall  = '0;
      for (int b = 0; b < W; b++) begin
        if (seen[b] != m_stable[b]) begin
          run[b]++;
          if (run[b] == D) begin
            m_stable[b] = seen[b];
            m_rise[b]   = seen[b];
            m_fall[b]   = ~seen[b];
            run[b]      = 0;
          end
        end else begin
          run[b] = 0;
        end
      end
      hist.push_back(in_raw);
      if (hist.size() > SYNC) void'(hist.pop_front());
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model in_stable", in_stable, m_stable);
    chk("model rise", rise, m_rise);
    chk("model fall", fall, m_fall);
    chk("model event", event_v, m_event);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    clr = '1;
    tick(1);
    clr = '0;
  endtask

  initial begin
    in_raw  = 4'hF;
    clr     = '0;
    reset_n = 1'b0;

    // 1: input high through reset, power-up report after release
    tick(3);
    chk("reset stable", in_stable, 4'h0);
    chk("reset rise", rise, 4'h0);
    chk("reset event", event_v, 4'h0);
    reset_n = 1'b1;
    tick(9);
    chk("t1 before accept", in_stable, 4'h0);
    tick(1);
    chk("t1 stable", in_stable, 4'hF);
    chk("t1 rise", rise, 4'hF);
    tick(1);
    chk("t1 rise one cycle", rise, 4'h0);
    chk("t1 event", event_v, 4'hF);
    clear_events();
    chk("t1 event cleared", event_v, 4'h0);

    // 2: clean step on bit0
    in_raw = 4'hE;
    tick(12);
    clear_events();
    in_raw = 4'hF;
    tick(9);
    chk("t2 before accept", in_stable, 4'hE);
    tick(1);
    chk("t2 stable", in_stable, 4'hF);
    chk("t2 rise", rise, 4'h1);
    tick(1);
    chk("t2 rise one cycle", rise, 4'h0);

    // 3: bit1 bounce 5 high, 1 low, then held high
    in_raw = 4'hD;
    tick(12);
    clear_events();
    in_raw = 4'hF;
    tick(5);
    in_raw = 4'hD;
    tick(1);
    in_raw = 4'hF;
    tick(9);
    chk("t3 before accept", in_stable, 4'hD);
    tick(1);
    chk("t3 stable", in_stable, 4'hF);
    chk("t3 rise", rise, 4'h2);

    // 4: 7-cycle glitch on bit2
    in_raw = 4'hB;
    tick(12);
    clear_events();
    in_raw = 4'hF;
    tick(7);
    in_raw = 4'hB;
    tick(12);
    chk("t4 stable", in_stable, 4'hB);
    chk("t4 event", event_v, 4'h0);

    // 5: clear coinciding with a new fall on bit3
    in_raw = 4'h3;
    tick(12);
    in_raw = 4'hB;
    tick(12);
    in_raw = 4'h3;
    tick(10);
    chk("t5 fall", fall, 4'h8);
    clr = 4'h8;
    tick(1);
    chk("t5 set wins", event_v & 4'h8, 4'h8);
    tick(1);
    chk("t5 cleared", event_v & 4'h8, 4'h0);
    clr = '0;

    // 6: reset during a bit0 count
    in_raw = 4'h2;
    tick(7);
    reset_n = 1'b0;
    in_raw  = 4'h1;
    #1;
    chk("t6 stable", in_stable, 4'h0);
    chk("t6 event", event_v, 4'h0);
    tick(2);
    reset_n = 1'b1;
    tick(9);
    chk("t6 before accept", in_stable, 4'h0);
    tick(1);
    chk("t6 stable after", in_stable, 4'h1);
    chk("t6 rise", rise, 4'h1);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
